pipeline_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS pipeline. Arbitrates hazard-unit requests
//  (load-use, branch, jump), a fixed-latency mult/div unit in EX and imem/dmem wait states.

---
 rtl/pipe_ctrl_pkg.sv | 12 +
 rtl/pipe_perf_cnt.sv | 16 +
 rtl/pipeline_ctrl.sv | 121 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding, cause codes and MD counter width for the pipeline controller
package pipe_ctrl_pkg;
   typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;
   localparam logic [2:0] CAUSE_NONE = 3'd0;
   localparam logic [2:0] CAUSE_DMEM = 3'd1;
   localparam logic [2:0] CAUSE_MD   = 3'd2;
   localparam logic [2:0] CAUSE_BR   = 3'd3;
   localparam logic [2:0] CAUSE_JMP  = 3'd4;
   localparam logic [2:0] CAUSE_LU   = 3'd5;
   localparam logic [2:0] CAUSE_IMEM = 3'd6;
   localparam int MD_CNT_W = 6;
endpackage

// File: rtl/pipe_perf_cnt.sv
// pipe_perf_cnt: saturating event counter
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count this cycle
//   cnt        : current count, sticks at all-ones
module pipe_perf_cnt #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage MIPS pipeline
//   Inputs : clk, rst_n (async, active-low), lu_stall, br_flush, j_flush, md_start,
//            imem_ready, dmem_req, dmem_ready
//   Outputs: pc_en, per-register en/flush, md_busy, cause (3b),
//            stall_cnt/flush_cnt (CNT_W, live only when PIPE_PERF_CNT_EN is defined)
import pipe_ctrl_pkg::*;
module pipeline_ctrl #(
   parameter int MD_LATENCY = 32,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             lu_stall,
   input  logic             br_flush,
   input  logic             j_flush,
   input  logic             md_start,
   input  logic             imem_ready,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_en,
   output logic             id_ex_flush,
   output logic             ex_mem_en,
   output logic             ex_mem_flush,
   output logic             mem_wb_en,
   output logic             md_busy,
   output logic [2:0]       cause,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   state_t              state, state_nx;
   logic [MD_CNT_W-1:0] md_cnt, md_cnt_nx;
   logic                live;
   logic                dmem_wait;

   assign dmem_wait = dmem_req & ~dmem_ready;
   assign md_busy   = (state == MD_WAIT);

   // live gives one dead cycle after reset release
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state  <= RUN;
         md_cnt <= '0;
         live   <= 1'b0;
      end else begin
         state  <= state_nx;
         md_cnt <= md_cnt_nx;
         live   <= 1'b1;
      end

   always_comb begin
      state_nx     = state;
      md_cnt_nx    = md_cnt;
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_en     = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_en    = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_en    = 1'b0;
      cause        = CAUSE_NONE;
      // a data-memory wait freezes the whole pipe, including the MD countdown
      if (live && !dmem_wait) begin
         if (state == MD_WAIT) begin
            if (md_cnt == '0) state_nx = RUN;
            else md_cnt_nx = md_cnt - 1'b1;
         end else if (md_start && !br_flush) begin
            state_nx  = MD_WAIT;
            md_cnt_nx = MD_CNT_W'(MD_LATENCY - 1);
         end
      end
      if (!live) begin
         cause = CAUSE_NONE;
      end else if (dmem_wait) begin
         cause = CAUSE_DMEM;
      end else if (state == MD_WAIT) begin
         ex_mem_en    = 1'b1;
         ex_mem_flush = 1'b1;
         mem_wb_en    = 1'b1;
         cause        = CAUSE_MD;
      end else begin
         pc_en     = 1'b1;
         if_id_en  = 1'b1;
         id_ex_en  = 1'b1;
         ex_mem_en = 1'b1;
         mem_wb_en = 1'b1;
         if (br_flush) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            cause       = CAUSE_BR;
         end else if (j_flush) begin
            if_id_flush = 1'b1;
            cause       = CAUSE_JMP;
         end else if (lu_stall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            cause       = CAUSE_LU;
         end else if (!imem_ready) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
            cause       = CAUSE_IMEM;
         end
      end
   end

`ifdef PIPE_PERF_CNT_EN
   pipe_perf_cnt #(.W(CNT_W)) u_stall_cnt (
      .clk(clk), .rst_n(rst_n), .inc(live & ~pc_en), .cnt(stall_cnt)
   );
   pipe_perf_cnt #(.W(CNT_W)) u_flush_cnt (
      .clk(clk), .rst_n(rst_n), .inc(live & if_id_flush), .cnt(flush_cnt)
   );
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and randomized checks of pipeline_ctrl against a behavioural model
module tb_pipeline_ctrl;
   localparam int MDL  = 4;
   localparam int CW   = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0, rst_n = 1'b0;
   logic lu_stall = 1'b0, br_flush = 1'b0, j_flush = 1'b0, md_start = 1'b0;
   logic imem_ready = 1'b1, dmem_req = 1'b0, dmem_ready = 1'b1;
   logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_en, md_busy;
   logic [2:0] cause;
   logic [CW-1:0] stall_cnt, flush_cnt;
   logic [11:0] out_v;

   pipeline_ctrl #(.MD_LATENCY(MDL), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .lu_stall(lu_stall), .br_flush(br_flush), .j_flush(j_flush),
      .md_start(md_start), .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
      .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush),
      .mem_wb_en(mem_wb_en), .md_busy(md_busy), .cause(cause),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // {pc, if_id en/flush, id_ex en/flush, ex_mem en/flush, mem_wb en, md_busy, cause}
   assign out_v = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush,
                   mem_wb_en, md_busy, cause};

   always #5 clk = ~clk;

   int vec = 0, err = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vec++;
      if (got !== exp) begin
         err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // behavioural model: md_rem = MD cycles still owed, counters as plain ints
   bit m_live;
   int m_rem, m_sc, m_fc;
   logic [11:0] m_exp;

   function automatic logic [11:0] model_out();
      logic busy;
      busy = (m_rem > 0);
      if (!m_live)                 return 12'h000;
      if (dmem_req && !dmem_ready) return {8'b0000_0000, busy, 3'd1};
      if (busy)                    return {8'b0000_0111, 1'b1, 3'd2};
      if (br_flush)                return {8'b1111_1101, 1'b0, 3'd3};
      if (j_flush)                 return {8'b1111_0101, 1'b0, 3'd4};
      if (lu_stall)                return {8'b0001_1101, 1'b0, 3'd5};
      if (!imem_ready)             return {8'b0111_0101, 1'b0, 3'd6};
      return {8'b1101_0101, 1'b0, 3'd0};
   endfunction

   task automatic model_reset();
      m_live = 1'b0;
      m_rem  = 0;
      m_sc   = 0;
      m_fc   = 0;
   endtask

   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         if (!rst_n) model_reset();
         m_exp = model_out();
         chk("outputs", {20'b0, out_v}, {20'b0, m_exp});
`ifdef PIPE_PERF_CNT_EN
         chk("stall_cnt", {24'b0, stall_cnt}, m_sc);
         chk("flush_cnt", {24'b0, flush_cnt}, m_fc);
`else
         chk("stall_cnt", {24'b0, stall_cnt}, 0);
         chk("flush_cnt", {24'b0, flush_cnt}, 0);
`endif
         @(posedge clk);
         if (!rst_n) model_reset();
         else if (!m_live) m_live = 1'b1;
         else begin
            if (!m_exp[11] && m_sc < CMAX) m_sc++;
            if (m_exp[9] && m_fc < CMAX) m_fc++;
            if (dmem_req && !dmem_ready) ;
            else if (m_rem > 0) m_rem--;
            else if (md_start && !br_flush) m_rem = MDL;
         end
      end
   end

   task automatic step(input logic l, b, j, m, ir, dq, dr);
      @(posedge clk);
      #1;
      lu_stall = l; br_flush = b; j_flush = j; md_start = m;
      imem_ready = ir; dmem_req = dq; dmem_ready = dr;
      @(negedge clk);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 1, 0, 1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_held", {20'b0, out_v}, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("dead_cycle", {20'b0, out_v}, 0);
      idle();                       chk("first_run", {20'b0, out_v}, 12'hD50);
      step(1, 0, 0, 0, 1, 0, 1);    chk("lu", {20'b0, out_v}, 12'h1D5);
      idle();                       chk("after_lu", {20'b0, out_v}, 12'hD50);
      step(1, 1, 1, 0, 1, 0, 1);    chk("br_prio", {20'b0, out_v}, 12'hFD3);
      step(0, 0, 1, 0, 1, 0, 1);    chk("jmp", {20'b0, out_v}, 12'hF54);
      step(0, 0, 0, 0, 0, 0, 1);    chk("imem", {20'b0, out_v}, 12'h756);
      step(0, 1, 0, 1, 1, 0, 1);    chk("br_md", {20'b0, out_v}, 12'hFD3);
      idle();                       chk("br_md_ignored", {20'b0, out_v}, 12'hD50);
      step(0, 0, 0, 1, 1, 0, 1);    chk("md_issue", {20'b0, out_v}, 12'hD50);
      for (int i = 0; i < 4; i++) begin
         idle();                    chk("md_wait", {20'b0, out_v}, 12'h07A);
      end
      idle();                       chk("md_done", {20'b0, out_v}, 12'hD50);
      step(0, 0, 0, 1, 1, 0, 1);
      idle();                       chk("md_wait2", {20'b0, out_v}, 12'h07A);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 1, 1, 0); chk("md_dmem", {20'b0, out_v}, 12'h009);
      end
      for (int i = 0; i < 3; i++) begin
         idle();                    chk("md_resume", {20'b0, out_v}, 12'h07A);
      end
      idle();                       chk("md_late_done", {20'b0, out_v}, 12'hD50);
      step(1, 1, 0, 0, 0, 1, 0);    chk("dmem", {20'b0, out_v}, 12'h001);
      step(0, 0, 0, 1, 1, 0, 1);
      idle();                       chk("md_pre_rst", {20'b0, out_v}, 12'h07A);
      #2 rst_n = 1'b0;
      #1 chk("async_rst", {20'b0, out_v}, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);               chk("dead_cycle2", {20'b0, out_v}, 0);
      idle();                       chk("md_aborted", {20'b0, out_v}, 12'hD50);
      repeat (5) step(1, 0, 0, 0, 1, 0, 1);
      repeat (2) step(0, 0, 1, 0, 1, 0, 1);
      idle();
`ifdef PIPE_PERF_CNT_EN
      chk("stall_cnt_5", {24'b0, stall_cnt}, 5);
      chk("flush_cnt_2", {24'b0, flush_cnt}, 2);
`else
      chk("stall_cnt_off", {24'b0, stall_cnt}, 0);
      chk("flush_cnt_off", {24'b0, flush_cnt}, 0);
`endif
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         rst_n      = ($urandom_range(0, 499) != 0);
         lu_stall   = ($urandom_range(0, 99) < 15);
         br_flush   = ($urandom_range(0, 99) < 10);
         j_flush    = ($urandom_range(0, 99) < 10);
         md_start   = ($urandom_range(0, 99) < 8);
         imem_ready = ($urandom_range(0, 99) < 80);
         dmem_req   = ($urandom_range(0, 99) < 30);
         dmem_ready = ($urandom_range(0, 99) < 50);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule
